y_serial_adder: RTL and testbench
=================================

Y_SERIAL_ADDER -- requirements
Module: y_serial_adder

Interface
- REQ-001: Parameter WIDTH, default 4, is the operand width in bits (legal range 2..32).
- REQ-002: Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
- REQ-003: Port reset, input, 1 bit, is the asynchronous active-high reset.
- REQ-004: Port start, input, 1 bit, is the request to begin an operation; it is sampled only in IDLE.
- REQ-005: Port op, input, 1 bit, selects the operation: 0 = add, 1 = subtract (a - b).
- REQ-006: Port a, input, WIDTH bits, is operand A.
- REQ-007: Port b, input, WIDTH bits, is operand B.
- REQ-008: Port cin, input, 1 bit, is the carry-in; it is used only when op=0.
- REQ-009: Port busy, output, 1 bit, is high while the block is in RUN.
- REQ-010: Port done, output, 1 bit, is a one-cycle pulse marking that the result is valid.
- REQ-011: Port z, output, WIDTH bits, is the result.
- REQ-012: Port cout, output, 1 bit, is the carry-out of the MSB.

Function
- REQ-013: The block SHALL implement a state machine with states IDLE, RUN and DONE.
- REQ-014: In IDLE with start=1, the block SHALL, on that edge (the acceptance edge E0), perform all of the following:
  - latch a into the A shift register;
  - latch b into the B shift register, inverted when op=1;
  - load the carry flop with cin when op=0, or with 1 when op=1;
  - clear the bit counter;
  - go to RUN.
- REQ-015: In RUN, each edge E1..EWIDTH SHALL do the following:
  - feed the shift-register LSBs and the carry flop through one 1-bit full-adder cell;
  - shift the sum bit into z from the MSB side;
  - update the carry flop;
  - shift A and B right and increment the counter.
- REQ-016: At edge EWIDTH the block SHALL enter DONE, with z holding the full result and cout holding the final carry.
- REQ-017: done SHALL be high only while the state is DONE, which lasts exactly one cycle; the next edge returns the block to IDLE.
- REQ-018: z and cout SHALL hold their values from DONE until the next acceptance edge.
- REQ-019: z and cout SHALL NOT be interpreted while busy=1, because they are intermediate values.
- REQ-020: start SHALL be ignored in RUN and DONE, and no request is queued; start held high through DONE is accepted on the first IDLE cycle.
- REQ-021: Changes on a, b, op or cin after E0 SHALL NOT affect the operation in progress.
- REQ-022: The bit counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
- REQ-023: Asserting reset at any time, including mid-RUN, SHALL immediately force all of the following, aborting any operation with no done pulse:
  - state IDLE, busy=0, done=0;
  - z=0, cout=0;
  - shift registers, carry flop and counter to 0.
- REQ-024: The first edge after reset deasserts SHALL be able to accept start.

Configuration
- REQ-025: When YSA_OVERFLOW_EN is defined, the block SHALL have an additional output port ovf (1 bit) equal to the XOR of the carry into the MSB cell and the carry out of the MSB cell (two's-complement overflow).
- REQ-026: ovf SHALL be valid and held under the same rules as cout, and SHALL reset to 0.
- REQ-027: When YSA_OVERFLOW_EN is undefined, the ovf port and its flop SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-028: The shared package y_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant.
- REQ-029: The bit datapath SHALL be one instance of the existing 1-bit full-adder cell yAdder1, with ports (z, cout, a, b, cin); it is the only sub-module.

Verification
- REQ-030: The bench SHALL cover the following directed scenarios, all at WIDTH=4:
  - add a=0011, b=0101, cin=0, op=0 -> z=1000, cout=0; busy high for 4 cycles; done pulses in the cycle after E4.
  - add a=1111, b=0001, cin=0 -> z=0000, cout=1; with YSA_OVERFLOW_EN, ovf=0. add a=0111, b=0001 -> z=1000, cout=0, ovf=1.
  - subtract a=0101, b=0011, op=1 (cin=0 ignored) -> z=0010, cout=1. subtract a=0011, b=0101 -> z=1110, cout=0.
  - start pulsed at E2 with different operands during RUN -> ignored; the first result is unchanged; the second start is accepted only from IDLE.
  - reset asserted mid-RUN after E2 -> z=0, cout=0, busy=0 immediately; no done pulse; a new add of 0001+0001 after release -> z=0010.
  - exhaustive a, b, cin at WIDTH=4 with back-to-back starts -> every result equals a+b+cin (z = low 4 bits, cout = bit 4); done count equals start count.

Source files
------------

// File: rtl/y_pkg.sv
// Shared constants for the bit-serial adder/subtractor.
// FSM state encodings and the default operand width.
package y_pkg;
  localparam int Y_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/yAdder1.sv
// 1-bit full-adder cell.
// The only arithmetic element of the serial datapath.
module yAdder1 (
  output logic z,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign z    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/y_serial_adder.sv
// Bit-serial add/subtract, one bit per clock through a single yAdder1.
// Define YSA_OVERFLOW_EN to add the signed-overflow output ovf.
module y_serial_adder
  import y_pkg::*;
#(
  parameter int WIDTH = Y_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout
`ifdef YSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_z;
  logic             r_c;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;

  yAdder1 u_add (
    .z   (w_s),
    .cout(w_co),
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_c)
  );

  // Subtract is a + ~b + 1, so the carry flop doubles as the +1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= op ? ~b : b;
            r_c     <= op | cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_z    <= {w_s, r_z[WIDTH-1:1]};
          r_c    <= w_co;
          r_cout <= w_co;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST)
            r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef YSA_OVERFLOW_EN
  logic r_ovf;

  // On the last RUN edge r_c is the carry into the MSB cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (r_state == RUN)
      r_ovf <= r_c ^ w_co;
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign z    = r_z;
  assign cout = r_cout;
endmodule

// File: tb/tb_y_serial_adder.sv
// Directed bench for y_serial_adder at WIDTH=4.
// Build with +define+YSA_OVERFLOW_EN to also check ovf.
module tb_y_serial_adder;
  logic       clk;
  logic       reset;
  logic       start;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [3:0] z;
  logic       cout;
`ifdef YSA_OVERFLOW_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int done_pulses = 0;

  y_serial_adder #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .z    (z),
    .cout (cout)
`ifdef YSA_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_pulses++;

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(
    input  logic [3:0] ta,
    input  logic [3:0] tbv,
    input  logic       top,
    input  logic       tc,
    output logic [3:0] rz,
    output logic       rc,
    output logic       rv,
    output int         nbusy,
    output bit         to
  );
    wait_idle();
    a = ta; b = tbv; op = top; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tbv; op = ~top; cin = ~tc;
    nbusy = 0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
    rz = z;
    rc = cout;
`ifdef YSA_OVERFLOW_EN
    rv = ovf;
`else
    rv = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0;
    a = 4'h0; b = 4'h0; cin = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, z, cout} !== 7'b0) begin
      n_mis++;
      $display("FAIL reset_outputs got busy=%b done=%b z=%b cout=%b want all 0",
               busy, done, z, cout);
    end
`ifdef YSA_OVERFLOW_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [3:0] rz;
    logic rc, rv;
    int nb;
    bit to;
    run_op(4'b0011, 4'b0101, 1'b0, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b1000 || rc !== 1'b0) begin
      n_mis++;
      $display("FAIL add_3_5 got z=%b cout=%b to=%0d want z=1000 cout=0", rz, rc, to);
    end
    n_cmp++;
    if (nb !== 4) begin
      n_mis++;
      $display("FAIL add_busy_cycles got %0d want 4", nb);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy);
    end
    n_cmp++;
    if (z !== 4'b1000 || cout !== 1'b0) begin
      n_mis++;
      $display("FAIL result_hold got z=%b cout=%b want 1000 0", z, cout);
    end
  endtask

  task automatic test_add_carry();
    logic [3:0] rz;
    logic rc, rv;
    int nb;
    bit to;
    run_op(4'b1111, 4'b0001, 1'b0, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b0000 || rc !== 1'b1) begin
      n_mis++;
      $display("FAIL add_15_1 got z=%b cout=%b want z=0000 cout=1", rz, rc);
    end
`ifdef YSA_OVERFLOW_EN
    n_cmp++;
    if (rv !== 1'b0) begin
      n_mis++;
      $display("FAIL ovf_15_1 got %b want 0", rv);
    end
`endif
    run_op(4'b0111, 4'b0001, 1'b0, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b1000 || rc !== 1'b0) begin
      n_mis++;
      $display("FAIL add_7_1 got z=%b cout=%b want z=1000 cout=0", rz, rc);
    end
`ifdef YSA_OVERFLOW_EN
    n_cmp++;
    if (rv !== 1'b1) begin
      n_mis++;
      $display("FAIL ovf_7_1 got %b want 1", rv);
    end
`endif
  endtask

  task automatic test_sub();
    logic [3:0] rz;
    logic rc, rv;
    int nb;
    bit to;
    run_op(4'b0101, 4'b0011, 1'b1, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b0010 || rc !== 1'b1) begin
      n_mis++;
      $display("FAIL sub_5_3 got z=%b cout=%b want z=0010 cout=1", rz, rc);
    end
    run_op(4'b0011, 4'b0101, 1'b1, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b1110 || rc !== 1'b0) begin
      n_mis++;
      $display("FAIL sub_3_5 got z=%b cout=%b want z=1110 cout=0", rz, rc);
    end
  endtask

  task automatic test_start_ignored();
    logic [3:0] rz;
    logic rc, rv;
    int nb;
    bit to;
    wait_idle();
    a = 4'b0011; b = 4'b0101; op = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'hF; b = 4'hF; cin = 1'b1; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (to || z !== 4'b1000 || cout !== 1'b0) begin
      n_mis++;
      $display("FAIL start_in_run got z=%b cout=%b want z=1000 cout=0", z, cout);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL start_not_queued got busy=%b done=%b want 0 0", busy, done);
    end
    run_op(4'b0001, 4'b0010, 1'b0, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b0011 || rc !== 1'b0) begin
      n_mis++;
      $display("FAIL second_start got z=%b cout=%b want z=0011 cout=0", rz, rc);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] rz;
    logic rc, rv;
    int nb, dp;
    bit to;
    wait_idle();
    a = 4'hF; b = 4'hF; op = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dp = done_pulses;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (z !== 4'b0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_mid_run got z=%b cout=%b busy=%b done=%b want all 0",
               z, cout, busy, done);
    end
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (done_pulses !== dp) begin
      n_mis++;
      $display("FAIL reset_no_done got %0d pulses want %0d", done_pulses, dp);
    end
    run_op(4'b0001, 4'b0001, 1'b0, 1'b0, rz, rc, rv, nb, to);
    n_cmp++;
    if (to || rz !== 4'b0010 || rc !== 1'b0) begin
      n_mis++;
      $display("FAIL after_reset_add got z=%b cout=%b want z=0010 cout=0", rz, rc);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] expv;
    logic [8:0] v9;
    int n_start, d0;
    bit to;
    wait_idle();
    @(posedge clk); #1;
    d0 = done_pulses;
    n_start = 0;
    op = 1'b0;
    start = 1'b1;
    for (int v = 0; v < 512; v++) begin
      v9 = 9'(v);
      a = v9[8:5]; b = v9[4:1]; cin = v9[0];
      expv = {1'b0, v9[8:5]} + {1'b0, v9[4:1]} + {4'b0, v9[0]};
      n_start++;
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done) begin
          to = 1'b0;
          break;
        end
      end
      n_cmp++;
      if (to || {cout, z} !== expv) begin
        n_mis++;
        $display("FAIL b2b a=%b b=%b cin=%b got %b want %b", v9[8:5], v9[4:1],
                 v9[0], {cout, z}, expv);
      end
      if (to) break;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (done_pulses - d0 !== n_start) begin
      n_mis++;
      $display("FAIL b2b_done_count got %0d want %0d", done_pulses - d0, n_start);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_carry();
    test_sub();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
